// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT butterfly: mode encoding and modular add/sub helpers.
// The halve helper exists only when NTT_BUTTERFLY_HALVE_EN is defined.
package ntt_pkg;

  // Helpers work on a fixed wide word; callers zero-extend and truncate to DATA_W.
  localparam int unsigned NTT_MAX_W = 64;

  localparam logic MODE_CT = 1'b0;
  localparam logic MODE_GS = 1'b1;

  function automatic logic [NTT_MAX_W-1:0] mod_add(input logic [NTT_MAX_W-1:0] x,
                                                   input logic [NTT_MAX_W-1:0] y,
                                                   input logic [NTT_MAX_W-1:0] q);
    logic [NTT_MAX_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) begin
      s = s - {1'b0, q};
    end else begin
      s = s;
    end
    return s[NTT_MAX_W-1:0];
  endfunction

  function automatic logic [NTT_MAX_W-1:0] mod_sub(input logic [NTT_MAX_W-1:0] x,
                                                   input logic [NTT_MAX_W-1:0] y,
                                                   input logic [NTT_MAX_W-1:0] q);
    logic [NTT_MAX_W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) begin
      d = d + {1'b0, q};
    end else begin
      d = d;
    end
    return d[NTT_MAX_W-1:0];
  endfunction

`ifdef NTT_BUTTERFLY_HALVE_EN
  // x * 2^-1 mod q; odd q makes x+q even whenever x is odd.
  function automatic logic [NTT_MAX_W-1:0] halve(input logic [NTT_MAX_W-1:0] x,
                                                 input logic [NTT_MAX_W-1:0] q);
    logic [NTT_MAX_W:0] t;
    if (x[0]) begin
      t = {1'b0, x} + {1'b0, q};
    end else begin
      t = {1'b0, x};
    end
    return t[NTT_MAX_W:1];
  endfunction
`endif

endpackage

// File: rtl/mod_mul_pipe.sv
// Pipelined modular multiplier: p = x*y mod q, fixed LAT-cycle latency, frozen when en=0.
// The raw product is registered first; the reduction feeds the final register.
module mod_mul_pipe
  import ntt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] p
);

  localparam int PW = 2 * DATA_W;

  function automatic logic [DATA_W-1:0] reduce(input logic [PW-1:0] v,
                                               input logic [DATA_W-1:0] m);
    return DATA_W'(v % PW'(m));
  endfunction

  logic [PW-1:0]     prod_s;
  logic [DATA_W-1:0] p_d;
  logic [DATA_W-1:0] p_q;

  always_comb begin
    prod_s = PW'(x) * PW'(y);
  end

  generate
    if (LAT == 1) begin : g_single
      always_comb begin
        if (en) begin
          p_d = reduce(prod_s, q);
        end else begin
          p_d = p_q;
        end
      end
    end else begin : g_multi
      logic [PW-1:0] pipe_q [LAT-1];
      logic [PW-1:0] pipe_d [LAT-1];

      always_comb begin
        if (en) begin
          pipe_d[0] = prod_s;
          for (int k = 1; k < LAT - 1; k++) begin
            pipe_d[k] = pipe_q[k-1];
          end
          p_d = reduce(pipe_q[LAT-2], q);
        end else begin
          for (int k = 0; k < LAT - 1; k++) begin
            pipe_d[k] = pipe_q[k];
          end
          p_d = p_q;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < LAT - 1; k++) begin
            pipe_q[k] <= {PW{1'b0}};
          end
        end else begin
          for (int k = 0; k < LAT - 1; k++) begin
            pipe_q[k] <= pipe_d[k];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= {DATA_W{1'b0}};
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// Fully pipelined radix-2 NTT butterfly, per-beat CT/GS mode, latency MUL_LAT+2, global stall.
// Define NTT_BUTTERFLY_HALVE_EN to halve both GS results (INTT n^-1 scaling).
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              valid_in,
  input  logic              mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] q,
  output logic              valid_out,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic              busy
);

  function automatic logic [NTT_MAX_W-1:0] ext(input logic [DATA_W-1:0] v);
    return NTT_MAX_W'(v);
  endfunction

  // Stage A: opa is a (CT) or s (GS); x is b (CT) or d (GS)
  logic              va_d, va_q;
  logic              mode_a_d, mode_a_q;
  logic [DATA_W-1:0] opa_a_d, opa_a_q;
  logic [DATA_W-1:0] x_a_d, x_a_q;
  logic [DATA_W-1:0] w_a_d, w_a_q;

  // Stage M side channel delayed in lockstep with the multiplier
  logic [MUL_LAT-1:0] vm_d, vm_q;
  logic [MUL_LAT-1:0] mode_m_d, mode_m_q;
  logic [DATA_W-1:0]  opa_m_d [MUL_LAT];
  logic [DATA_W-1:0]  opa_m_q [MUL_LAT];
  logic [DATA_W-1:0]  prod_s;

  // Stage C / outputs
  logic              vout_d, vout_q;
  logic [DATA_W-1:0] r0_d, r0_q;
  logic [DATA_W-1:0] r1_d, r1_q;
  logic [DATA_W-1:0] opa_c_s;

  always_comb begin
    if (stall) begin
      va_d     = va_q;
      mode_a_d = mode_a_q;
      opa_a_d  = opa_a_q;
      x_a_d    = x_a_q;
      w_a_d    = w_a_q;
    end else begin
      va_d     = valid_in;
      mode_a_d = mode;
      w_a_d    = w;
      if (mode == MODE_GS) begin
        opa_a_d = DATA_W'(mod_add(ext(a), ext(b), ext(q)));
        x_a_d   = DATA_W'(mod_sub(ext(a), ext(b), ext(q)));
      end else begin
        opa_a_d = a;
        x_a_d   = b;
      end
    end
  end

  mod_mul_pipe #(
    .DATA_W (DATA_W),
    .LAT    (MUL_LAT)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .en    (~stall),
    .x     (x_a_q),
    .y     (w_a_q),
    .q     (q),
    .p     (prod_s)
  );

  always_comb begin
    if (stall) begin
      vm_d     = vm_q;
      mode_m_d = mode_m_q;
      for (int k = 0; k < MUL_LAT; k++) begin
        opa_m_d[k] = opa_m_q[k];
      end
    end else begin
      vm_d[0]     = va_q;
      mode_m_d[0] = mode_a_q;
      opa_m_d[0]  = opa_a_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        vm_d[k]     = vm_q[k-1];
        mode_m_d[k] = mode_m_q[k-1];
        opa_m_d[k]  = opa_m_q[k-1];
      end
    end
  end

  always_comb begin
    opa_c_s = opa_m_q[MUL_LAT-1];
    if (stall) begin
      vout_d = vout_q;
      r0_d   = r0_q;
      r1_d   = r1_q;
    end else begin
      vout_d = vm_q[MUL_LAT-1];
      if (mode_m_q[MUL_LAT-1] == MODE_GS) begin
`ifdef NTT_BUTTERFLY_HALVE_EN
        r0_d = DATA_W'(halve(ext(opa_c_s), ext(q)));
        r1_d = DATA_W'(halve(ext(prod_s), ext(q)));
`else
        r0_d = opa_c_s;
        r1_d = prod_s;
`endif
      end else begin
        r0_d = DATA_W'(mod_add(ext(opa_c_s), ext(prod_s), ext(q)));
        r1_d = DATA_W'(mod_sub(ext(opa_c_s), ext(prod_s), ext(q)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      va_q     <= 1'b0;
      mode_a_q <= 1'b0;
      opa_a_q  <= {DATA_W{1'b0}};
      x_a_q    <= {DATA_W{1'b0}};
      w_a_q    <= {DATA_W{1'b0}};
      vm_q     <= {MUL_LAT{1'b0}};
      mode_m_q <= {MUL_LAT{1'b0}};
      for (int k = 0; k < MUL_LAT; k++) begin
        opa_m_q[k] <= {DATA_W{1'b0}};
      end
      vout_q   <= 1'b0;
      r0_q     <= {DATA_W{1'b0}};
      r1_q     <= {DATA_W{1'b0}};
    end else begin
      va_q     <= va_d;
      mode_a_q <= mode_a_d;
      opa_a_q  <= opa_a_d;
      x_a_q    <= x_a_d;
      w_a_q    <= w_a_d;
      vm_q     <= vm_d;
      mode_m_q <= mode_m_d;
      for (int k = 0; k < MUL_LAT; k++) begin
        opa_m_q[k] <= opa_m_d[k];
      end
      vout_q   <= vout_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
    end
  end

  assign valid_out = vout_q;
  assign r0        = r0_q;
  assign r1        = r1_q;
  assign busy      = va_q | (|vm_q) | vout_q;

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Randomised self-checking bench for ntt_butterfly_pipe (DATA_W=16, MUL_LAT=4) with a scoreboard.
// Expected results follow NTT_BUTTERFLY_HALVE_EN the same way the design build does.
module tb_ntt_butterfly_pipe;

  localparam int DATA_W  = 16;
  localparam int MUL_LAT = 4;
  localparam int L       = MUL_LAT + 2;

  logic              clk = 1'b0;
  logic              reset, stall, valid_in, mode;
  logic [DATA_W-1:0] a, b, w, q;
  logic              valid_out, busy;
  logic [DATA_W-1:0] r0, r1;

  ntt_butterfly_pipe #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .valid_in(valid_in), .mode(mode),
    .a(a), .b(b), .w(w), .q(q),
    .valid_out(valid_out), .r0(r0), .r1(r1), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint r0;
    longint r1;
    longint due;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cnt   = 0;   // unstalled, non-reset edges seen
  bit     adv   = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Reference butterfly straight from the CT/GS formulas
  function automatic void ref_bfly(input longint av, input longint bv, input longint wv,
                                   input bit m, input longint qv,
                                   output longint o0, output longint o1);
    longint t;
    if (m == 1'b0) begin
      t  = (bv * wv) % qv;
      o0 = (av + t) % qv;
      o1 = (av - t + qv) % qv;
    end else begin
      o0 = (av + bv) % qv;
      o1 = (((av - bv + qv) % qv) * wv) % qv;
`ifdef NTT_BUTTERFLY_HALVE_EN
      o0 = (o0 * ((qv + 1) / 2)) % qv;
      o1 = (o1 * ((qv + 1) / 2)) % qv;
`endif
    end
  endfunction

  always @(posedge clk) begin
    adv <= !stall && !reset;
    if (!stall && !reset) cnt <= cnt + 1;
  end

  // Scoreboard: each new output must match the oldest pending beat at its due cycle
  always @(negedge clk) begin
    if (adv) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_valid_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("latency", cnt, e.due);
          check_val("r0", r0, e.r0);
          check_val("r1", r1, e.r1);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cnt) begin
        check_val("missing_beat", cnt, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic issue(input int av, input int bv, input int wv, input bit m);
    exp_t e;
    longint o0, o1;
    a = DATA_W'(av); b = DATA_W'(bv); w = DATA_W'(wv); mode = m;
    valid_in = 1'b1;
    ref_bfly(av, bv, wv, m, longint'(q), o0, o1);
    e.r0 = o0; e.r1 = o1; e.due = cnt + L;
    exp_q.push_back(e);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    a = DATA_W'($urandom); b = DATA_W'($urandom);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic random_burst(input int n, input bit alternate);
    int qi;
    qi = int'(q);
    for (int i = 0; i < n; i++) begin
      issue($urandom_range(qi - 1, 0), $urandom_range(qi - 1, 0), $urandom_range(qi - 1, 0),
            alternate ? bit'(i % 2) : bit'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    logic [DATA_W-1:0] snap0, snap1;
    logic              snapv;
    reset = 1'b1; stall = 1'b0; valid_in = 1'b0; mode = 1'b0;
    a = '0; b = '0; w = '0; q = 16'd3329;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("rst_valid_out", valid_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_r0", r0, 0);
    check_val("rst_r1", r1, 0);

    // Directed vectors
    issue(100, 200, 17, 1'b0);
    check_val("busy_inflight", busy, 1);
    idle(L + 1);
    issue(100, 200, 17, 1'b1);
    idle(L + 1);
    issue(3328, 1, 1, 1'b0);
    issue(0, 1, 1, 1'b1);
    issue(3328, 3328, 3328, 1'b1);
    issue(0, 3328, 3328, 1'b0);
    drain();
    idle(1);
    check_val("idle_busy", busy, 0);

    // Back-to-back alternating CT/GS
    random_burst(64, 1'b1);
    drain();

    // Stall with 4 beats in flight: outputs frozen for 3 cycles
    random_burst(4, 1'b0);
    idle(1);
    stall = 1'b1;
    snapv = valid_out; snap0 = r0; snap1 = r1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("stall_vout_hold", valid_out, snapv);
      check_val("stall_r0_hold", r0, snap0);
      check_val("stall_r1_hold", r1, snap1);
    end
    stall = 1'b0;
    drain();

    // Reset while 5 beats in flight, with stall asserted
    random_burst(5, 1'b0);
    stall = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
    exp_q.delete();
    check_val("rstmid_valid_out", valid_out, 0);
    check_val("rstmid_busy", busy, 0);
    check_val("rstmid_r0", r0, 0);
    check_val("rstmid_r1", r1, 0);
    idle(2 * L);
    issue(100, 200, 17, 1'b0);
    drain();

    // Large modulus exercises the add/sub carry bit
    idle(2);
    q = 16'd65521;
    random_burst(32, 1'b0);
    issue(65520, 65520, 65520, 1'b0);
    issue(65520, 65520, 65520, 1'b1);
    drain();

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
